// File: rtl/fbuf_scanout.sv
// Framebuffer scan-out: 640x480@60 timing generator, BRAM read address generator
// and RGB332 -> RGB888 expansion, with sync/de delay-matched to the pixel data.
module fbuf_scanout #(
    parameter int H_ACTIVE           = 640,
    parameter int H_FP               = 16,
    parameter int H_SYNC             = 96,
    parameter int H_BP               = 48,
    parameter int V_ACTIVE           = 480,
    parameter int V_FP               = 10,
    parameter int V_SYNC             = 2,
    parameter int V_BP               = 33,
    parameter bit SYNC_ACTIVE_HIGH   = 1'b0,
    parameter int SCALE_SHIFT        = 0,
    parameter int FRAME_WIDTH_SCALED = 640,
    parameter int FBUF_ADDR_WIDTH    = 19,
    parameter int FBUF_DATA_WIDTH    = 8,
    parameter int FBUF_READ_LATENCY  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fbuf_rst_busy,
    output logic                       fbuf_en_rd,
    output logic [FBUF_ADDR_WIDTH-1:0] fbuf_addr,
    input  logic [FBUF_DATA_WIDTH-1:0] fbuf_data,
    output logic [7:0]                 video_r,
    output logic [7:0]                 video_g,
    output logic [7:0]                 video_b,
    output logic                       video_hsync,
    output logic                       video_vsync,
    output logic                       video_de,
    output logic                       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int AW      = FBUF_ADDR_WIDTH;
    localparam int SW      = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;
    localparam int L       = FBUF_READ_LATENCY + 2;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_MASK  = VW'((1 << SCALE_SHIFT) - 1);
    localparam logic [SW-1:0] SUB_MAX = SW'((1 << SCALE_SHIFT) - 1);
    localparam logic [AW-1:0] STRIDE  = AW'(FRAME_WIDTH_SCALED);
    localparam logic          SYNC_IDLE = SYNC_ACTIVE_HIGH ? 1'b0 : 1'b1;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic valid;
        logic fs;
    } tctl_t;

    logic [HW-1:0] h_cnt_reg, h_cnt_next;
    logic [VW-1:0] v_cnt_reg, v_cnt_next;
    logic [AW-1:0] col_reg, col_next;
    logic [SW-1:0] sub_reg, sub_next;
    logic [AW-1:0] row_base_reg, row_base_next;

    logic  h_wrap, v_wrap, line_act;
    tctl_t raw_ctl;
    tctl_t [L-2:0] ctl_reg;
    tctl_t tap;
    logic [7:0] pix;

    always_comb begin
        h_wrap        = (h_cnt_reg == H_LAST);
        v_wrap        = (v_cnt_reg == V_LAST);
        line_act      = (v_cnt_reg < V_ACT);
        raw_ctl.de    = (h_cnt_reg < H_ACT) && line_act;
        raw_ctl.hs    = (h_cnt_reg >= HS_BEG) && (h_cnt_reg < HS_END);
        raw_ctl.vs    = (v_cnt_reg >= VS_BEG) && (v_cnt_reg < VS_END);
        raw_ctl.fs    = (h_cnt_reg == '0) && (v_cnt_reg == '0);
        raw_ctl.valid = raw_ctl.de && !fbuf_rst_busy;
    end

    // Address walks the framebuffer incrementally: col steps once per 2^SCALE_SHIFT
    // pixels, row_base steps by one stride after the last screen line of each row.
    always_comb begin
        h_cnt_next    = h_wrap ? '0 : h_cnt_reg + HW'(1);
        v_cnt_next    = v_cnt_reg;
        col_next      = col_reg;
        sub_next      = sub_reg;
        row_base_next = row_base_reg;
        if (h_wrap) begin
            v_cnt_next = v_wrap ? '0 : v_cnt_reg + VW'(1);
            col_next   = '0;
            sub_next   = '0;
            if (v_wrap) begin
                row_base_next = '0;
            end else if (line_act && ((v_cnt_reg & V_MASK) == V_MASK)) begin
                row_base_next = row_base_reg + STRIDE;
            end
        end else if (raw_ctl.de) begin
            if (sub_reg == SUB_MAX) begin
                sub_next = '0;
                col_next = col_reg + AW'(1);
            end else begin
                sub_next = sub_reg + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_reg    <= '0;
            v_cnt_reg    <= '0;
            col_reg      <= '0;
            sub_reg      <= '0;
            row_base_reg <= '0;
        end else begin
            h_cnt_reg    <= h_cnt_next;
            v_cnt_reg    <= v_cnt_next;
            col_reg      <= col_next;
            sub_reg      <= sub_next;
            row_base_reg <= row_base_next;
        end
    end

    // Read issue stage; the control delay line starts here alongside the address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fbuf_en_rd <= 1'b0;
            fbuf_addr  <= '0;
            ctl_reg    <= '0;
        end else begin
            fbuf_en_rd <= raw_ctl.valid;
            fbuf_addr  <= row_base_reg + col_reg;
            ctl_reg[0] <= raw_ctl;
            for (int i = 1; i < L - 1; i++) begin
                ctl_reg[i] <= ctl_reg[i-1];
            end
        end
    end

    assign tap = ctl_reg[L-2];
    assign pix = fbuf_data[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            video_r     <= '0;
            video_g     <= '0;
            video_b     <= '0;
            video_de    <= 1'b0;
            video_hsync <= SYNC_IDLE;
            video_vsync <= SYNC_IDLE;
            frame_start <= 1'b0;
        end else begin
            video_de    <= tap.de;
            frame_start <= tap.fs;
            video_hsync <= tap.hs ? ~SYNC_IDLE : SYNC_IDLE;
            video_vsync <= tap.vs ? ~SYNC_IDLE : SYNC_IDLE;
            if (tap.valid && tap.de) begin
                video_r <= {pix[7:5], pix[7:5], pix[7:6]};
                video_g <= {pix[4:2], pix[4:2], pix[4:3]};
                video_b <= {pix[1:0], pix[1:0], pix[1:0], pix[1:0]};
            end else begin
                video_r <= '0;
                video_g <= '0;
                video_b <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fbuf_scanout.sv
// Bench for fbuf_scanout: reduced-size timing so whole frames fit in a short run;
// a second instance exercises pixel doubling (SCALE_SHIFT=1).
module tb_fbuf_scanout;

    localparam int HA  = 160, HFP  = 8, HSY  = 16, HBP  = 16, HT  = HA + HFP + HSY + HBP;
    localparam int VA  = 48,  VFP  = 3, VSY  = 2,  VBP  = 5,  VT  = VA + VFP + VSY + VBP;
    localparam int HA2 = 64,  HFP2 = 4, HSY2 = 8,  HBP2 = 4,  HT2 = HA2 + HFP2 + HSY2 + HBP2;
    localparam int VA2 = 48,  VFP2 = 2, VSY2 = 2,  VBP2 = 3,  VT2 = VA2 + VFP2 + VSY2 + VBP2;
    localparam int FW2 = 32;
    localparam int MEMSZ = HA * VA;
    localparam int L = 4;

    logic        clk, rst_n, busy, busy2;
    logic        en_rd, en_rd2;
    logic [18:0] addr, addr2;
    logic [7:0]  fbuf_data, fbuf_data2, rd1;
    logic [7:0]  vr, vg, vb, vr2, vg2, vb2;
    logic        hsync, vsync, de, fs, hsync2, vsync2, de2, fs2;

    fbuf_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .SYNC_ACTIVE_HIGH(1'b0), .SCALE_SHIFT(0), .FRAME_WIDTH_SCALED(HA),
        .FBUF_ADDR_WIDTH(19), .FBUF_DATA_WIDTH(8), .FBUF_READ_LATENCY(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fbuf_rst_busy(busy),
        .fbuf_en_rd(en_rd), .fbuf_addr(addr), .fbuf_data(fbuf_data),
        .video_r(vr), .video_g(vg), .video_b(vb),
        .video_hsync(hsync), .video_vsync(vsync), .video_de(de), .frame_start(fs)
    );

    fbuf_scanout #(
        .H_ACTIVE(HA2), .H_FP(HFP2), .H_SYNC(HSY2), .H_BP(HBP2),
        .V_ACTIVE(VA2), .V_FP(VFP2), .V_SYNC(VSY2), .V_BP(VBP2),
        .SYNC_ACTIVE_HIGH(1'b0), .SCALE_SHIFT(1), .FRAME_WIDTH_SCALED(FW2),
        .FBUF_ADDR_WIDTH(19), .FBUF_DATA_WIDTH(8), .FBUF_READ_LATENCY(2)
    ) dut_scaled (
        .clk(clk), .rst_n(rst_n), .fbuf_rst_busy(busy2),
        .fbuf_en_rd(en_rd2), .fbuf_addr(addr2), .fbuf_data(fbuf_data2),
        .video_r(vr2), .video_g(vg2), .video_b(vb2),
        .video_hsync(hsync2), .video_vsync(vsync2), .video_de(de2), .frame_start(fs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-cycle BRAM read model; ignores enable so gating must happen in the DUT.
    logic [7:0] mem [MEMSZ];
    always @(posedge clk) begin
        rd1       <= (int'(addr) < MEMSZ) ? mem[addr] : 8'h5A;
        fbuf_data <= rd1;
        fbuf_data2 <= addr2[7:0];
    end

    typedef struct {
        int unsigned addr;
        logic [7:0]  pix;
        logic [23:0] rgb;
    } cvec_t;
    cvec_t tbl[6];

    typedef struct {
        logic de, hs, vs, fs, valid;
        int unsigned addr;
    } exp_t;
    exp_t sbq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int s;
    int busy_lo, busy_hi;
    logic prev2_ok, prev2_valid;
    int unsigned prev2_addr;

    function automatic logic [23:0] expand(input logic [7:0] p);
        return {p[7:5], p[7:5], p[7:6], p[4:2], p[4:2], p[4:3], {4{p[1:0]}}};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, wanted %0h (state %0d)", name, act, exp, s);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_de"}, 32'(de), 0);
        check({tag, "_rgb"}, {8'h0, vr, vg, vb}, 0);
        check({tag, "_hsync"}, 32'(hsync), 1);
        check({tag, "_vsync"}, 32'(vsync), 1);
        check({tag, "_fs"}, 32'(fs), 0);
        check({tag, "_en_rd"}, 32'(en_rd), 0);
        check({tag, "_addr"}, 32'(addr), 0);
        check({tag, "_en_rd2"}, 32'(en_rd2), 0);
    endtask

    // Called at a falling edge: compare outputs, then drive busy and push the
    // expectation for the counter state about to be captured on the next rising edge.
    task automatic step();
        exp_t e, o;
        int h, v, h2, v2;
        if (sbq.size() >= L) begin
            o = sbq.pop_front();
            check("de", 32'(de), 32'(o.de));
            check("hsync", 32'(hsync), 32'(!o.hs));
            check("vsync", 32'(vsync), 32'(!o.vs));
            check("frame_start", 32'(fs), 32'(o.fs));
            check("rgb", {8'h0, vr, vg, vb}, o.valid ? {8'h0, expand(mem[o.addr])} : 32'h0);
        end else begin
            check("pre_de", 32'(de), 0);
            check("pre_fs", 32'(fs), 0);
            check("pre_rgb", {8'h0, vr, vg, vb}, 0);
        end
        if (s >= L && s < L + 6) begin
            check("rgb_table", {8'h0, vr, vg, vb}, {8'h0, tbl[s-L].rgb});
            $display("colour vector %0d: pix %02h -> rgb %02h%02h%02h", s - L, tbl[s-L].pix, vr, vg, vb);
        end
        if (sbq.size() > 0) begin
            check("en_rd", 32'(en_rd), 32'(sbq[$].valid));
            if (sbq[$].valid) check("addr", 32'(addr), sbq[$].addr);
        end else begin
            check("en_rd_idle", 32'(en_rd), 0);
        end
        if (prev2_ok) begin
            check("en_rd2", 32'(en_rd2), 32'(prev2_valid));
            if (prev2_valid) check("addr2", 32'(addr2), prev2_addr);
        end

        h = s % HT;
        v = (s / HT) % VT;
        busy = (s >= busy_lo && s < busy_hi);
        e.de    = (h < HA) && (v < VA);
        e.hs    = (h >= HA + HFP) && (h < HA + HFP + HSY);
        e.vs    = (v >= VA + VFP) && (v < VA + VFP + VSY);
        e.fs    = (h == 0) && (v == 0);
        e.valid = e.de && !busy;
        e.addr  = v * HA + h;
        sbq.push_back(e);

        h2 = s % HT2;
        v2 = (s / HT2) % VT2;
        prev2_valid = (h2 < HA2) && (v2 < VA2);
        prev2_addr  = (v2 / 2) * FW2 + h2 / 2;
        prev2_ok    = 1'b1;

        if (s > 0 && s % (HT * VT) == 0) $display("frame boundary at state %0d", s);
        s++;
        @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{0, 8'hE0, 24'hFF0000};
        tbl[1] = '{1, 8'h1C, 24'h00FF00};
        tbl[2] = '{2, 8'h03, 24'h0000FF};
        tbl[3] = '{3, 8'h92, 24'h9292AA};
        tbl[4] = '{4, 8'hFF, 24'hFFFFFF};
        tbl[5] = '{5, 8'h49, 24'h494955};
        for (int i = 0; i < MEMSZ; i++) mem[i] = 8'(i);
        for (int i = 0; i < 6; i++) mem[tbl[i].addr] = tbl[i].pix;

        rst_n = 1'b0;
        busy  = 1'b0;
        busy2 = 1'b0;
        s = 0;
        prev2_ok = 1'b0;
        prev2_valid = 1'b0;
        prev2_addr = 0;
        busy_lo = 10 * HT + 30;
        busy_hi = busy_lo + 100;

        repeat (3) begin
            @(negedge clk);
            check_reset("reset_hold");
        end
        rst_n = 1'b1;
        repeat (2 * HT * VT + 20 * HT + 50) step();

        // Asynchronous reset in the middle of an active line.
        #2 rst_n = 1'b0;
        #1 check_reset("async_reset");
        repeat (3) begin
            @(negedge clk);
            check_reset("async_hold");
        end
        sbq.delete();
        s = 0;
        prev2_ok = 1'b0;
        busy_lo = -1;
        busy_hi = -1;
        rst_n = 1'b1;
        repeat (HT * VT + 10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fbuf_scanout.md
# fbuf_scanout

Downstream stage of the framebuffer path. It generates 640x480@60 video timing, reads the framebuffer BRAM through the read port (the GPU AXI slave writes through the other port), and expands each 8-bit RGB332 pixel to 24-bit RGB. Sync and data-enable are delay-matched to the pixel data. The outputs feed the TMDS/HDMI encoder in the pixel-clock domain.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in clocks
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- SYNC_ACTIVE_HIGH, 0, sync polarity (0 = active-low)
- SCALE_SHIFT, 0, each framebuffer pixel covers 2^SCALE_SHIFT x 2^SCALE_SHIFT screen pixels
- FRAME_WIDTH_SCALED, 640, framebuffer row stride; equals H_ACTIVE>>SCALE_SHIFT
- FBUF_ADDR_WIDTH, 19, BRAM address width
- FBUF_DATA_WIDTH, 8, BRAM data width (RGB332)
- FBUF_READ_LATENCY, 2, clocks from registered address to valid fbuf_data

Ports:
- clk  in  1  pixel clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- fbuf_rst_busy  in  1  BRAM in reset; reads must not be issued
- fbuf_en_rd  out  1  BRAM read enable
- fbuf_addr  out  FBUF_ADDR_WIDTH  BRAM read address
- fbuf_data  in  FBUF_DATA_WIDTH  BRAM read data
- video_r / video_g / video_b  out  8 each  pixel colour
- video_hsync / video_vsync  out  1 each  sync outputs
- video_de  out  1  active-video enable
- frame_start  out  1  one-cycle pulse, aligned with output pixel (0,0)

## Operation
- Counters: h_cnt counts 0..H_TOTAL-1 (H_TOTAL = 800). v_cnt increments when h_cnt wraps and counts 0..V_TOTAL-1 (V_TOTAL = 525). Both counters reset to 0.
- Raw timing signals:
  - de = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE
  - hs active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751)
  - vs active for lines 490..491
  - polarity is applied per SYNC_ACTIVE_HIGH
- Address generation without a multiplier:
  - col advances by 1 every 2^SCALE_SHIFT active pixels.
  - row_base adds FRAME_WIDTH_SCALED at the end of each active line whose low SCALE_SHIFT bits of v_cnt are all ones.
  - col clears at line end. row_base clears at frame wrap.
  - fbuf_addr = row_base + col, truncated to FBUF_ADDR_WIDTH.
- Read gating: fbuf_en_rd = raw de && !fbuf_rst_busy. A valid bit (same condition) travels through the pipeline with the read.
- RGB332 expansion, for pixel p:
  - r = {p[7:5],p[7:5],p[7:6]}
  - g = {p[4:2],p[4:2],p[4:3]}
  - b = {p[1:0],p[1:0],p[1:0],p[1:0]}
  - If the valid bit is 0 or de is 0, RGB outputs are 0.
- Timing generation never stalls. fbuf_rst_busy only blanks pixel data; sync and de continue unchanged.

## Timing
- Pipeline: counter state at cycle n → fbuf_addr/fbuf_en_rd registered at n+1 → fbuf_data valid at n+1+FBUF_READ_LATENCY → all video_* and frame_start registered at n+2+FBUF_READ_LATENCY.
- Total output latency L = FBUF_READ_LATENCY+2, which is 4 by default. hs, vs, de and valid pass through an L-deep shift register so they stay aligned with the data.
- Reset values:
  - video_r/g/b = 0, video_de = 0, frame_start = 0
  - video_hsync and video_vsync at their inactive level (1 when SYNC_ACTIVE_HIGH = 0)
  - fbuf_en_rd = 0, fbuf_addr = 0
  - all delay-line stages cleared to their inactive values
- After release: counters start at (0,0) on the first rising edge. video_de first rises L cycles later, together with frame_start.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous). The frame restarts from (0,0) after release, with no partial-pipeline data emitted.
- fbuf_rst_busy is sampled at the counter stage. Pixels issued while busy output RGB 0 exactly L cycles later. Deassertion mid-line resumes valid data from the next issued pixel, at the correct address.
- At the last active pixel (639,479) the address is FRAME_WIDTH_SCALED*(V_ACTIVE>>SCALE_SHIFT)-1 (307199 by default). The following frame starts again at address 0.

## Test plan
- Reset: hold rst_n=0 → r/g/b=0, de=0, hsync=vsync=1, fbuf_en_rd=0. Release → de and frame_start first high at cycle 4.
- Timing: run 2 frames with BRAM model fbuf_data = addr[7:0].
  - Each line: 640 de cycles, hsync low for 96 cycles starting 656 cycles after de rise.
  - Each frame: vsync low on lines 490-491, frame_start every 420000 cycles.
  - Addresses per line: row*640+0..639.
- Colour: pixels 0xE0, 0x1C, 0x03, 0x92 → RGB FF0000, 00FF00, 0000FF, 9292AA.
- Scale: SCALE_SHIFT=1, FRAME_WIDTH_SCALED=320 → each address is repeated for 2 consecutive pixels. Lines 0 and 1 both read 0..319, line 2 starts at 320, and the final address is 76799.
- Busy: assert fbuf_rst_busy for 100 cycles mid-line → fbuf_en_rd=0 and 100 output pixels are 0 with de still high. Timing counters are unaffected and data resumes correctly.
- Async reset mid-frame at line 200: outputs go to reset values within the same cycle. After release, the first address issued is 0 and frame_start appears 4 cycles after the first edge.
